clk_div_prog: RTL and testbench
===============================

# clk_div_prog

Programmable, multi-channel clock divider: the successor to the fixed ripple divide-by-2048 chain. A single fast clock drives NUM_CH independent counter-based channels. Each channel has a runtime-configurable integer ratio (2..2^CNT_W-1), including odd ratios, and its own enable. Outputs are flop-driven divided clocks plus one-cycle period-start ticks, used by the accelerator's slow housekeeping and sampling logic. Ratio and enable changes go through a valid/ready config port and take effect only at a period boundary, so no output ever glitches or produces a runt pulse.

## Interface
Parameters:
- NUM_CH, 4: number of independent divider channels (1..16)
- CNT_W, 12: divisor/counter width; max ratio 2^CNT_W-1
- CH_W, $clog2(NUM_CH) (min 1): channel index width

Ports:
- clk  in  1  single system clock; all logic on posedge
- rst_n  in  1  asynchronous, active-low reset; one clock; reset is asynchronous and active-low
- cfg_valid  in  1  config request valid
- cfg_ready  out  1  config request accepted when high with cfg_valid
- cfg_ch  in  CH_W  target channel
- cfg_div  in  CNT_W  divide ratio D
- cfg_en  in  1  1 = run at D, 0 = stop channel (cfg_div ignored)
- cfg_err  out  1  one-cycle pulse: last accepted request rejected
- div_clk  out  NUM_CH  divided clocks, one per channel
- div_tick  out  NUM_CH  one-cycle pulse at the first cycle of each period
- ch_busy  out  NUM_CH  channel running

## Operation
- Per channel: run flag, divisor D, counter cnt, pending flag, pending D/en.
- Running: cnt counts 0..D-1 then wraps to 0. div_clk=1 exactly in cycles with cnt >= ceil(D/2); low phase first. Examples: D=2 gives 1 low, 1 high; D=3 gives 2 low, 1 high; D=5 gives 3 low, 2 high.
- div_tick=1 in cycles where run=1 and cnt==0.
- Idle (run=0): cnt=0, div_clk=0, div_tick=0, ch_busy=0.
- cfg_ready = !pending[cfg_ch], combinational. Out-of-range cfg_ch gives cfg_ready=1.
- Accept = cfg_valid & cfg_ready. Reject conditions: cfg_ch >= NUM_CH, or cfg_en=1 with cfg_div<2. On reject, cfg_err pulses the next cycle and no state changes.
- Accepted valid request to an idle channel with cfg_en=1: applied at the accept edge. D is loaded, cnt<=0, run<=1.
- Accepted request to an idle channel with cfg_en=0: no-op, no error.
- Accepted request to a running channel:
  - If the channel is at its wrap edge (cnt==D-1) in the same cycle, the request is applied at that edge with no pending stage.
  - Otherwise pending<=1 and the request is applied at the next wrap edge.
- Apply at a wrap edge: if en=1, D<=new D and cnt<=0; if en=0, run<=0. pending clears at the same edge.
- A stop therefore always completes the current full period. div_clk returns low with no truncated high phase.
- Channels are fully independent. Simultaneous wraps on multiple channels are each handled.

## Timing
- Reset (async assert): div_clk=0, div_tick=0, ch_busy=0, cfg_err=0, all pending=0, all run=0, so cfg_ready=1.
- Deassertion is synchronized by the system; first accept can occur at the first posedge after deassertion.
- Reset mid-period forces outputs low immediately. There is no completion of the current period.
- Idle start: accept at edge k. Cycle k+1 has cnt=0, div_tick=1, ch_busy=1, div_clk=0.
- Running update: the old D governs through cnt==D_old-1. The cycle after the wrap edge has cnt=0 and the new D.
- cfg_ready on the updated channel rises in the cycle after the apply edge.
- cfg_err is registered: high in cycle k+1 for a rejection at edge k, for one cycle per rejection.
- All outputs are flop outputs (cfg_ready excepted). No combinational path from cfg_* to div_clk or div_tick.

## Test plan
- Reset, then ch0 D=4 en=1: div_tick at k+1, k+5, k+9; div_clk pattern 0,0,1,1 repeating; ch_busy[0]=1.
- ch1 D=5: low 3 cycles, high 2 cycles; period 5; tick aligned with the first low cycle.
- ch0 running D=4, request D=6 at cnt=1: cfg_ready[0]=0 until the wrap. The period is still 4, then periods of 6 follow. Same request at cnt=3: applied immediately, no busy gap.
- Stop ch2 (en=0) mid high phase: high phase completes, wrap, then div_clk=0, ch_busy=0, no further ticks.
- Rejects: D=1 en=1 gives cfg_err one cycle, state unchanged. cfg_ch=NUM_CH gives cfg_err. D=0 en=0 to an idle channel gives no error.
- Assert rst_n low mid-period with 3 channels running: all outputs 0 asynchronously. After release, channels stay idle until reconfigured.

Source files
------------

// File: rtl/clk_div_prog.sv
// clk_div_prog
//   Programmable multi-channel clock divider. Each channel divides clk by an
//   integer ratio D (2..2^CNT_W-1). The low phase comes first, and the high
//   phase lasts floor(D/2) cycles. Each channel also produces a one-cycle tick
//   at the start of every period. Ratio and enable changes are accepted on a
//   valid/ready port. A change to a running channel takes effect only at that
//   channel's period boundary, so no output ever glitches or produces a runt
//   pulse.
//
// Ports
//   clk        system clock, all logic on posedge
//   rst_n      asynchronous active-low reset
//   cfg_valid  config request valid
//   cfg_ready  request accepted when high together with cfg_valid (combinational)
//   cfg_ch     target channel
//   cfg_div    divide ratio D
//   cfg_en     1 = run at D, 0 = stop the channel at the end of its period
//   cfg_err    one-cycle pulse after an accepted request was rejected
//   div_clk    divided clocks, one per channel
//   div_tick   one-cycle pulse in the first cycle of each period
//   ch_busy    channel running
module clk_div_prog #(
  parameter int NUM_CH = 4,
  parameter int CNT_W  = 12,
  parameter int CH_W   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cfg_valid,
  output logic              cfg_ready,
  input  logic [CH_W-1:0]   cfg_ch,
  input  logic [CNT_W-1:0]  cfg_div,
  input  logic              cfg_en,
  output logic              cfg_err,
  output logic [NUM_CH-1:0] div_clk,
  output logic [NUM_CH-1:0] div_tick,
  output logic [NUM_CH-1:0] ch_busy
);

  logic [NUM_CH-1:0] run_q, run_n;
  logic [NUM_CH-1:0] pend_q, pend_n;
  logic [NUM_CH-1:0] pend_en_q, pend_en_n;
  logic [CNT_W-1:0]  d_q [NUM_CH];
  logic [CNT_W-1:0]  d_n [NUM_CH];
  logic [CNT_W-1:0]  cnt_q [NUM_CH];
  logic [CNT_W-1:0]  cnt_n [NUM_CH];
  logic [CNT_W-1:0]  pend_d_q [NUM_CH];
  logic [CNT_W-1:0]  pend_d_n [NUM_CH];
  logic [CNT_W-1:0]  half_n [NUM_CH];
  logic [NUM_CH-1:0] hit, wrap, clk_n, tick_n;
  logic              acc, bad;

  // Channels outside the implemented range always report ready.
  // Requests to them are then flagged as errors.
  always_comb begin
    cfg_ready = 1'b1;
    for (int i = 0; i < NUM_CH; i++)
      if (cfg_ch == CH_W'(i)) cfg_ready = !pend_q[i];
  end

  always_comb begin
    acc = cfg_valid && cfg_ready;
    bad = (int'(cfg_ch) >= NUM_CH) || (cfg_en && (cfg_div < CNT_W'(2)));
    for (int i = 0; i < NUM_CH; i++) begin
      run_n[i]     = run_q[i];
      pend_n[i]    = pend_q[i];
      pend_en_n[i] = pend_en_q[i];
      d_n[i]       = d_q[i];
      cnt_n[i]     = cnt_q[i];
      pend_d_n[i]  = pend_d_q[i];
      hit[i]       = acc && !bad && (int'(cfg_ch) == i);
      wrap[i]      = run_q[i] && (cnt_q[i] == d_q[i] - CNT_W'(1));

      if (!run_q[i]) begin
        cnt_n[i] = '0;
        if (hit[i] && cfg_en) begin
          run_n[i] = 1'b1;
          d_n[i]   = cfg_div;
        end
      end else if (wrap[i]) begin
        // A request arriving exactly on the wrap edge is applied directly.
        // A pending request cannot coexist with it, because ready was low.
        cnt_n[i]  = '0;
        pend_n[i] = 1'b0;
        if (pend_q[i]) begin
          if (pend_en_q[i]) d_n[i] = pend_d_q[i];
          else              run_n[i] = 1'b0;
        end else if (hit[i]) begin
          if (cfg_en) d_n[i] = cfg_div;
          else        run_n[i] = 1'b0;
        end
      end else begin
        cnt_n[i] = cnt_q[i] + CNT_W'(1);
        if (hit[i]) begin
          pend_n[i]    = 1'b1;
          pend_d_n[i]  = cfg_div;
          pend_en_n[i] = cfg_en;
        end
      end

      // The outputs are registered from next-state values.
      // This keeps them aligned with the counter value of the same cycle.
      half_n[i] = (d_n[i] >> 1) + CNT_W'(d_n[i][0]);
      clk_n[i]  = run_n[i] && (cnt_n[i] >= half_n[i]);
      tick_n[i] = run_n[i] && (cnt_n[i] == '0);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      run_q     <= '0;
      pend_q    <= '0;
      pend_en_q <= '0;
      div_clk   <= '0;
      div_tick  <= '0;
      cfg_err   <= 1'b0;
      for (int i = 0; i < NUM_CH; i++) begin
        d_q[i]      <= '0;
        cnt_q[i]    <= '0;
        pend_d_q[i] <= '0;
      end
    end else begin
      run_q     <= run_n;
      pend_q    <= pend_n;
      pend_en_q <= pend_en_n;
      div_clk   <= clk_n;
      div_tick  <= tick_n;
      cfg_err   <= acc && bad;
      for (int i = 0; i < NUM_CH; i++) begin
        d_q[i]      <= d_n[i];
        cnt_q[i]    <= cnt_n[i];
        pend_d_q[i] <= pend_d_n[i];
      end
    end
  end

  assign ch_busy = run_q;

endmodule

// File: tb/tb_clk_div_prog.sv
// tb_clk_div_prog
//   Directed bench for clk_div_prog. It uses three channels, so channel
//   index 3 is out of range. Inputs are driven 1 ns after each rising edge,
//   and outputs are sampled at the same point.
module tb_clk_div_prog;
  localparam int NUM_CH = 3;
  localparam int CNT_W  = 8;
  localparam int CH_W   = 2;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              cfg_valid = 1'b0;
  logic              cfg_ready;
  logic [CH_W-1:0]   cfg_ch = '0;
  logic [CNT_W-1:0]  cfg_div = '0;
  logic              cfg_en = 1'b0;
  logic              cfg_err;
  logic [NUM_CH-1:0] div_clk, div_tick, ch_busy;

  int errors = 0;
  int checks = 0;

  clk_div_prog #(.NUM_CH(NUM_CH), .CNT_W(CNT_W), .CH_W(CH_W)) dut (
    .clk(clk), .rst_n(rst_n), .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
    .cfg_ch(cfg_ch), .cfg_div(cfg_div), .cfg_en(cfg_en), .cfg_err(cfg_err),
    .div_clk(div_clk), .div_tick(div_tick), .ch_busy(ch_busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Present a request for one edge, then drop cfg_valid.
  task automatic send(input int ch, input int d, input int e);
    cfg_valid = 1'b1;
    cfg_ch    = ch[CH_W-1:0];
    cfg_div   = d[CNT_W-1:0];
    cfg_en    = e[0];
    step();
    cfg_valid = 1'b0;
  endtask

  initial begin
    // Reset state
    #2;
    chk("rst_clk", div_clk, 0);
    chk("rst_tick", div_tick, 0);
    chk("rst_busy", ch_busy, 0);
    chk("rst_err", cfg_err, 0);
    chk("rst_ready", cfg_ready, 1);
    step();
    rst_n = 1'b1;

    // ch0 D=4: tick every 4 cycles, clk 0,0,1,1
    cfg_ch = 2'd0;
    chk("t1_ready", cfg_ready, 1);
    send(0, 4, 1);
    for (int j = 0; j < 12; j++) begin
      chk("t1_tick0", div_tick[0], (j % 4) == 0);
      chk("t1_clk0", div_clk[0], (j % 4) >= 2);
      chk("t1_busy0", ch_busy[0], 1);
      step();
    end

    // ch1 D=5: 3 low, 2 high. ch0 keeps its D=4 pattern, starting at cnt=1.
    send(1, 5, 1);
    for (int j = 0; j < 10; j++) begin
      chk("t2_tick1", div_tick[1], (j % 5) == 0);
      chk("t2_clk1", div_clk[1], (j % 5) >= 3);
      chk("t2_clk0", div_clk[0], ((1 + j) % 4) >= 2);
      chk("t2_tick0", div_tick[0], ((1 + j) % 4) == 0);
      step();
    end

    // ch0 is at cnt=3 here. Advance to cnt=1, then request D=6.
    step();
    step();
    cfg_valid = 1'b1; cfg_ch = 2'd0; cfg_div = 8'd6; cfg_en = 1'b1;
    chk("t3_ready_pre", cfg_ready, 1);
    step();
    cfg_valid = 1'b0;
    chk("t3_ready_pend_a", cfg_ready, 0);
    chk("t3_clk_c2", div_clk[0], 1);
    step();
    chk("t3_ready_pend_b", cfg_ready, 0);
    chk("t3_clk_c3", div_clk[0], 1);
    step();
    chk("t3_ready_after", cfg_ready, 1);
    for (int j = 0; j < 12; j++) begin
      chk("t3_tick0_d6", div_tick[0], (j % 6) == 0);
      chk("t3_clk0_d6", div_clk[0], (j % 6) >= 3);
      step();
    end

    // A request on the wrap edge (cnt=5 of D=6) applies with no pending stage.
    repeat (5) step();
    cfg_valid = 1'b1; cfg_ch = 2'd0; cfg_div = 8'd4; cfg_en = 1'b1;
    chk("t3b_ready_wrap", cfg_ready, 1);
    step();
    cfg_valid = 1'b0;
    chk("t3b_ready_post", cfg_ready, 1);
    for (int j = 0; j < 8; j++) begin
      chk("t3b_tick0_d4", div_tick[0], (j % 4) == 0);
      chk("t3b_clk0_d4", div_clk[0], (j % 4) >= 2);
      step();
    end

    // Stop ch2 in its high phase. The high phase completes, then the channel is idle.
    send(2, 4, 1);
    chk("t4_tick2", div_tick[2], 1);
    step();
    step();
    chk("t4_clk2_high", div_clk[2], 1);
    send(2, 0, 0);
    cfg_ch = 2'd2;
    chk("t4_clk2_c3", div_clk[2], 1);
    chk("t4_busy2_c3", ch_busy[2], 1);
    chk("t4_ready2_pend", cfg_ready, 0);
    step();
    for (int j = 0; j < 6; j++) begin
      chk("t4_clk2_off", div_clk[2], 0);
      chk("t4_tick2_off", div_tick[2], 0);
      chk("t4_busy2_off", ch_busy[2], 0);
      step();
    end
    chk("t4_ready2_idle", cfg_ready, 1);

    // Rejected and no-op requests
    send(2, 1, 1);
    chk("t5_err_d1", cfg_err, 1);
    chk("t5_busy2_d1", ch_busy[2], 0);
    step();
    chk("t5_err_clear", cfg_err, 0);
    send(1, 1, 1);
    chk("t5_err_run_d1", cfg_err, 1);
    cfg_ch = 2'd1;
    chk("t5_ready1_unchanged", cfg_ready, 1);
    cfg_valid = 1'b1; cfg_ch = 2'd3; cfg_div = 8'd5; cfg_en = 1'b1;
    chk("t5_ready_oor", cfg_ready, 1);
    step();
    cfg_valid = 1'b0;
    chk("t5_err_oor", cfg_err, 1);
    chk("t5_busy_oor", ch_busy, 3'b011);
    send(2, 0, 0);
    chk("t5_err_noop", cfg_err, 0);
    chk("t5_busy2_noop", ch_busy[2], 0);

    // ch2 D=3: 2 low, 1 high, then an asynchronous reset mid-period.
    send(2, 3, 1);
    chk("t6_tick2", div_tick[2], 1);
    chk("t6_clk2_c0", div_clk[2], 0);
    step();
    chk("t6_clk2_c1", div_clk[2], 0);
    step();
    chk("t6_clk2_c2", div_clk[2], 1);
    chk("t6_busy_all", ch_busy, 3'b111);
    #2;
    rst_n = 1'b0;
    #1;
    chk("t6_rst_clk", div_clk, 0);
    chk("t6_rst_tick", div_tick, 0);
    chk("t6_rst_busy", ch_busy, 0);
    chk("t6_rst_err", cfg_err, 0);
    chk("t6_rst_ready", cfg_ready, 1);
    step();
    rst_n = 1'b1;
    for (int j = 0; j < 6; j++) begin
      step();
      chk("t6_idle_busy", ch_busy, 0);
      chk("t6_idle_clk", div_clk, 0);
      chk("t6_idle_tick", div_tick, 0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
